stage_banner_sequencer: RTL and testbench

//  Control FSM upstream of the 80x40 stage-start banner drawers and their erase block; sits between game-state control and the VGA adapter.
//  On a stage request it enables the selected banner drawer, generates the VGA plot strobe aligned to the drawer's pixel stream,

---
 rtl/stage_banner_sequencer.sv | 121 ++++++++++++
 tb/tb_stage_banner_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_banner_sequencer.sv
// Sequences a stage-start banner: draw, hold on screen, erase, then report ready.
// Generates the VGA plot strobe aligned to the drawer/eraser pixel stream.
module stage_banner_sequencer #(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned HOLD_W       = 26,
  parameter int unsigned DONE_TIMEOUT = 4_000,
  parameter int unsigned TO_W         = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stage,
  input  logic [1:0] stage_num,
  input  logic       banner_done,
  input  logic       erase_done,
  output logic [1:0] stage_sel,
  output logic       draw_enable,
  output logic       erase_enable,
  output logic       plot,
  output logic       busy,
  output logic       stage_ready,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StHold,
    StErase,
    StFinish
  } state_e;

  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   ToLast   = TO_W'(DONE_TIMEOUT - 1);
  localparam logic [1:0]        PhaseRun = 2'd2;

  state_e            state;
  logic [1:0]        phase;
  logic [TO_W-1:0]   to_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              pass_done;

  // Drawers keep a stale done from the previous pass for two cycles; only trust it once streaming.
  assign pass_done = (phase == PhaseRun) &&
                     (((state == StDraw) && banner_done) || ((state == StErase) && erase_done));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      phase        <= 2'd0;
      to_cnt       <= '0;
      hold_cnt     <= '0;
      stage_sel    <= 2'd0;
      draw_enable  <= 1'b0;
      erase_enable <= 1'b0;
      plot         <= 1'b0;
      busy         <= 1'b0;
      stage_ready  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      stage_ready <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_stage) begin
            state       <= StDraw;
            stage_sel   <= stage_num;
            phase       <= 2'd0;
            to_cnt      <= '0;
            draw_enable <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StDraw, StErase: begin
          if (pass_done) begin
            draw_enable  <= 1'b0;
            erase_enable <= 1'b0;
            plot         <= 1'b0;
            if (state == StDraw) begin
              state    <= StHold;
              hold_cnt <= '0;
            end else begin
              state       <= StFinish;
              stage_ready <= 1'b1;
            end
          end else if (to_cnt == ToLast) begin
            state        <= StIdle;
            draw_enable  <= 1'b0;
            erase_enable <= 1'b0;
            plot         <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (phase != PhaseRun) begin
              phase <= phase + 2'd1;
            end
            // Pixel stream starts two cycles after entry; plot follows the next phase value.
            plot <= (phase != 2'd0);
          end
        end
        StHold: begin
          if (hold_cnt == HoldLast) begin
            state        <= StErase;
            erase_enable <= 1'b1;
            phase        <= 2'd0;
            to_cnt       <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        StFinish: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_banner_sequencer.sv
// Randomized bench for stage_banner_sequencer; expected outputs come from a per-pass
// timeline of cycle intervals computed when a request is accepted.
module tb_stage_banner_sequencer;

  localparam int H    = 10;
  localparam int TO   = 4000;
  localparam int NCYC = 60000;
  localparam int INF  = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stage = 1'b0;
  logic [1:0] stage_num = 2'd0;
  logic       banner_done = 1'b0;
  logic       erase_done = 1'b0;
  logic [1:0] stage_sel;
  logic       draw_enable, erase_enable, plot, busy, stage_ready, timeout_err;

  int n_tests = 0;
  int n_fail = 0;

  // Timeline of the most recently accepted pass (absolute cycle numbers).
  int   p_valid = 0, p_idx = -1, pass_no = 0;
  int   p_d, p_dd, p_draw_last, p_e, p_ed, p_erase_last, p_f, p_idle, p_err_at;
  int   p_has_erase, p_has_finish;
  logic [1:0] p_sel;
  logic [1:0] m_sel = 2'd0;
  logic       m_err = 1'b0;
  int   nom_plots = 0, nom_ready = 0, nom_checked = 0;

  stage_banner_sequencer #(
    .HOLD_CYCLES (H),
    .HOLD_W      (26),
    .DONE_TIMEOUT(TO),
    .TO_W        (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_stage (start_stage),
    .stage_num   (stage_num),
    .banner_done (banner_done),
    .erase_done  (erase_done),
    .stage_sel   (stage_sel),
    .draw_enable (draw_enable),
    .erase_enable(erase_enable),
    .plot        (plot),
    .busy        (busy),
    .stage_ready (stage_ready),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int pick_len(input int r);
    if (r == 0) return 3200;
    if (r == 1) return TO - 2;
    if (r == 2) return TO - 1;
    if (r == 3) return TO + 500;
    return 1 + int'($urandom_range(39, 0));
  endfunction

  // Build the interval timeline for a pass accepted during cycle t.
  task automatic accept(input int t, input int ld, input int le, input logic [1:0] sel);
    p_valid = 1;
    p_idx = pass_no;
    pass_no++;
    p_sel = sel;
    p_d = t + 1;
    p_err_at = INF;
    p_has_finish = 0;
    if (ld <= TO - 2) begin
      p_has_erase = 1;
      p_dd = p_d + 1 + ld;
      p_draw_last = p_dd;
      p_e = p_dd + 1 + H;
      if (le <= TO - 2) begin
        p_has_finish = 1;
        p_ed = p_e + 1 + le;
        p_erase_last = p_ed;
        p_f = p_ed + 1;
        p_idle = p_f + 1;
      end else begin
        p_erase_last = p_e + TO - 1;
        p_idle = p_e + TO;
        p_err_at = p_idle;
      end
    end else begin
      p_has_erase = 0;
      p_draw_last = p_d + TO - 1;
      p_idle = p_d + TO;
      p_err_at = p_idle;
    end
  endtask

  initial begin
    logic [7:0] exp_o;
    logic       e_busy, e_de, e_ee, e_plot, e_sr, idle_now, go;
    int         ld, le;
    logic [1:0] num;

    repeat (3) @(negedge clk);
    check_eq("reset_state", 32'({stage_sel, draw_enable, erase_enable, plot, busy,
                                 stage_ready, timeout_err}), 32'd0);
    reset = 1'b0;

    // Reset in the middle of a draw pass.
    start_stage = 1'b1;
    stage_num = 2'd1;
    @(negedge clk);
    start_stage = 1'b0;
    check_eq("draw_entry_en", 32'(draw_enable), 32'd1);
    check_eq("draw_entry_plot", 32'(plot), 32'd0);
    repeat (102) @(negedge clk);
    check_eq("plot_px100", 32'(plot), 32'd1);
    check_eq("sel_px100", 32'(stage_sel), 32'd1);
    #2 reset = 1'b1;
    #1 check_eq("reset_async", 32'({stage_sel, draw_enable, erase_enable, plot, busy,
                                    stage_ready, timeout_err}), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check_eq("reset_held", 32'({stage_ready, busy, plot}), 32'd0);
    end
    reset = 1'b0;

    for (int t = 0; t < NCYC && n_fail < 20; t++) begin
      if (p_valid != 0 && t == p_d) m_sel = p_sel;
      if (p_valid != 0 && t == p_err_at) m_err = 1'b1;
      e_busy = (p_valid != 0) && t >= p_d && t < p_idle;
      e_de   = (p_valid != 0) && t >= p_d && t <= p_draw_last;
      e_ee   = (p_valid != 0) && (p_has_erase != 0) && t >= p_e && t <= p_erase_last;
      e_plot = (p_valid != 0) && ((t >= p_d + 2 && t <= p_draw_last) ||
               ((p_has_erase != 0) && t >= p_e + 2 && t <= p_erase_last));
      e_sr   = (p_valid != 0) && (p_has_finish != 0) && t == p_f;
      exp_o  = {m_sel, e_de, e_ee, e_plot, e_busy, e_sr, m_err};
      check_eq("outs", 32'({stage_sel, draw_enable, erase_enable, plot, busy, stage_ready,
                            timeout_err}), 32'(exp_o));

      // Nominal first pass: 3200 draw plots plus 3200 erase plots, one ready pulse.
      if (p_idx == 0 && t >= p_d && t < p_idle) begin
        nom_plots += int'(plot);
        nom_ready += int'(stage_ready);
      end
      if (p_idx == 0 && t == p_idle && nom_checked == 0) begin
        nom_checked = 1;
        check_eq("nominal_plots", 32'(nom_plots), 32'd6400);
        check_eq("nominal_ready", 32'(nom_ready), 32'd1);
      end

      // Drawer/eraser models: stale done at entry, done on last pixel, noise where ignored.
      banner_done = 1'($urandom_range(1, 0));
      erase_done  = 1'($urandom_range(1, 0));
      if (p_valid != 0) begin
        if (t >= p_d && t < p_d + 2) banner_done = ($urandom_range(3, 0) != 0);
        else if (t >= p_d + 2 && t <= p_draw_last)
          banner_done = (p_has_erase != 0) && t == p_dd;
        if (p_has_erase != 0) begin
          if (t >= p_e && t < p_e + 2) erase_done = ($urandom_range(3, 0) != 0);
          else if (t >= p_e + 2 && t <= p_erase_last)
            erase_done = (p_has_finish != 0) && t == p_ed;
        end
      end

      idle_now = (p_valid == 0) || t >= p_idle;
      num = 2'($urandom_range(3, 0));
      if (idle_now) begin
        go = ($urandom_range(2, 0) == 0) ||
             ((p_valid != 0) && (p_has_finish != 0) && t == p_idle &&
              $urandom_range(1, 0) == 1);
      end else begin
        go = ($urandom_range(15, 0) == 0) ||
             ((p_has_finish != 0) && t == p_f && $urandom_range(1, 0) == 1);
      end
      if (idle_now && go) begin
        case (pass_no)
          0: begin ld = 3200; le = 3200; num = 2'd2; end
          1: begin ld = TO + 100; le = 1; end
          2: begin ld = 5; le = TO; end
          3: begin ld = TO - 2; le = 1; end
          default: begin
            ld = pick_len(int'($urandom_range(19, 0)));
            le = pick_len(int'($urandom_range(19, 0)));
          end
        endcase
        accept(t, ld, le, num);
      end
      start_stage = go;
      stage_num = num;
      @(negedge clk);
    end

    check_eq("nominal_seen", 32'(nom_checked), 32'd1);
    check_eq("passes_run", 32'(pass_no > 8), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
